// File: rtl/hazard_stall_controller.sv
// hazard_stall_controller
// Pipeline sequencing for the 5-stage core. It handles the hazards that
// forwarding cannot resolve:
//   - load-use stalls
//   - taken-branch flushes resolved in EX
//   - multi-cycle data-memory waits in MEM, with a timeout abort
// Outputs are combinational from the registered state and the current inputs.
// Optional build macro: HAZARD_PERF_CNT_EN adds three 16-bit saturating
// performance counters. Control behaviour is the same in both builds.
module hazard_stall_controller #(
   parameter int unsigned REG_W        = 5,
   parameter int unsigned NULL_REG     = 31,
   parameter int unsigned LOAD_BUBBLES = 1,
   parameter int unsigned MEM_TIMEOUT  = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic             id_uses_rt,
   input  logic [REG_W-1:0] ex_rd,
   input  logic             ex_mem_read,
   input  logic             ex_branch_taken,
   input  logic             mem_req,
   input  logic             mem_ready,
   output logic             pc_write,
   output logic             ifid_write,
   output logic             idex_write,
   output logic             exmem_write,
   output logic             ifid_flush,
   output logic             idex_flush,
   output logic             memwb_bubble,
   output logic             mem_err,
   output logic [1:0]       state
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [15:0]      perf_load_stalls,
   output logic [15:0]      perf_mem_waits,
   output logic [15:0]      perf_flushes
`endif
);

   typedef enum logic [1:0] {
      ST_RUN        = 2'd0,
      ST_LOAD_STALL = 2'd1,
      ST_MEM_WAIT   = 2'd2
   } state_t;

   localparam logic [REG_W-1:0] NULL_IDX    = REG_W'(NULL_REG);
   localparam logic [2:0]       BUB_INIT    = 3'(LOAD_BUBBLES - 1);
   localparam logic [15:0]      TIMEOUT_CNT = 16'(MEM_TIMEOUT - 1);

   state_t      state_r;
   state_t      ret_state_r;
   logic [2:0]  bub_cnt_r;
   logic [15:0] wait_cnt_r;

   logic   lu_s;
   logic   ms_s;
   logic   timeout_s;
   logic   freeze_s;
   logic   branch_s;
   logic   load_use_s;
   logic   load_hold_s;
   state_t eff_state_s;

   // Decode hazards and pick the single active rule for this cycle
   always_comb begin
      lu_s = ex_mem_read && (ex_rd != NULL_IDX) &&
             ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));
      ms_s = mem_req && !mem_ready;
      // Leaving MEM_WAIT resumes the rules of the state that was interrupted
      case (state_r)
         ST_RUN:        eff_state_s = ST_RUN;
         ST_LOAD_STALL: eff_state_s = ST_LOAD_STALL;
         ST_MEM_WAIT:   eff_state_s = ret_state_r;
         default:       eff_state_s = ST_RUN;
      endcase
      timeout_s   = (state_r == ST_MEM_WAIT) && ms_s && (wait_cnt_r == TIMEOUT_CNT);
      freeze_s    = ms_s && !timeout_s;
      branch_s    = !ms_s && ex_branch_taken;
      load_use_s  = !ms_s && !ex_branch_taken && (eff_state_s == ST_RUN) && lu_s;
      load_hold_s = !ms_s && !ex_branch_taken && (eff_state_s == ST_LOAD_STALL);
   end

   // Stage-register enables, squashes and the abort pulse
   always_comb begin
      pc_write     = 1'b1;
      ifid_write   = 1'b1;
      idex_write   = 1'b1;
      exmem_write  = 1'b1;
      ifid_flush   = 1'b0;
      idex_flush   = 1'b0;
      memwb_bubble = 1'b0;
      mem_err      = 1'b0;
      if (rst) begin
         pc_write     = 1'b0;
         ifid_write   = 1'b0;
         idex_write   = 1'b0;
         exmem_write  = 1'b0;
         ifid_flush   = 1'b1;
         idex_flush   = 1'b1;
         memwb_bubble = 1'b1;
      end else if (freeze_s) begin
         pc_write     = 1'b0;
         ifid_write   = 1'b0;
         idex_write   = 1'b0;
         exmem_write  = 1'b0;
         memwb_bubble = 1'b1;
      end else if (timeout_s) begin
         // Access is dropped; the pipeline advances past it
         mem_err      = 1'b1;
         memwb_bubble = 1'b1;
      end else if (branch_s) begin
         ifid_flush   = 1'b1;
         idex_flush   = 1'b1;
      end else if (load_use_s || load_hold_s) begin
         pc_write     = 1'b0;
         ifid_write   = 1'b0;
         idex_flush   = 1'b1;
      end else begin
         pc_write     = 1'b1;
         idex_flush   = 1'b0;
      end
   end

   // Sequencer state, bubble countdown and memory-wait counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= ST_RUN;
         ret_state_r <= ST_RUN;
         bub_cnt_r   <= 3'd0;
         wait_cnt_r  <= 16'd0;
      end else if (freeze_s) begin
         if (state_r != ST_MEM_WAIT) begin
            ret_state_r <= eff_state_s;
            wait_cnt_r  <= 16'd1;
            state_r     <= ST_MEM_WAIT;
         end else begin
            wait_cnt_r  <= wait_cnt_r + 16'd1;
         end
      end else if (timeout_s) begin
         wait_cnt_r <= 16'd0;
         state_r    <= ret_state_r;
      end else begin
         wait_cnt_r <= 16'd0;
         if (branch_s) begin
            bub_cnt_r <= 3'd0;
            state_r   <= ST_RUN;
         end else if (load_use_s) begin
            if (LOAD_BUBBLES > 1) begin
               bub_cnt_r <= BUB_INIT;
               state_r   <= ST_LOAD_STALL;
            end else begin
               state_r   <= ST_RUN;
            end
         end else if (load_hold_s) begin
            bub_cnt_r <= bub_cnt_r - 3'd1;
            // The cycle that consumes the last owed bubble returns to RUN
            if (bub_cnt_r <= 3'd1) begin
               state_r <= ST_RUN;
            end else begin
               state_r <= ST_LOAD_STALL;
            end
         end else begin
            state_r <= ST_RUN;
         end
      end
   end

   assign state = state_r;

`ifdef HAZARD_PERF_CNT_EN
   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      if (v == 16'hFFFF) begin
         sat_inc = v;
      end else begin
         sat_inc = v + 16'd1;
      end
   endfunction

   // Saturating counts of cycles spent in each kind of pipeline disturbance
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_load_stalls <= 16'd0;
         perf_mem_waits   <= 16'd0;
         perf_flushes     <= 16'd0;
      end else begin
         if (load_use_s || load_hold_s) begin
            perf_load_stalls <= sat_inc(perf_load_stalls);
         end else begin
            perf_load_stalls <= perf_load_stalls;
         end
         if (freeze_s) begin
            perf_mem_waits <= sat_inc(perf_mem_waits);
         end else begin
            perf_mem_waits <= perf_mem_waits;
         end
         if (branch_s) begin
            perf_flushes <= sat_inc(perf_flushes);
         end else begin
            perf_flushes <= perf_flushes;
         end
      end
   end
`endif

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Bench for hazard_stall_controller. Two instances share one stimulus stream:
//   - dut_a: LOAD_BUBBLES=1, MEM_TIMEOUT=64
//   - dut_b: LOAD_BUBBLES=3, MEM_TIMEOUT=4
// Every cycle, each instance is compared against a counter-based reference
// model. Table vectors and corner-case sequences also carry constant
// expectations.
module tb_hazard_stall_controller;

   localparam int LB_A = 1;
   localparam int T_A  = 64;
   localparam int LB_B = 3;
   localparam int T_B  = 4;

   // Output vector: {pc, ifid_w, idex_w, exmem_w, ifid_fl, idex_fl, bubble, err, state[1:0]}
   localparam logic [9:0] O_RUN  = 10'b1111_0000_00;
   localparam logic [9:0] O_RUN2 = 10'b1111_0000_10;
   localparam logic [9:0] O_LU0  = 10'b0011_0100_00;
   localparam logic [9:0] O_LU1  = 10'b0011_0100_01;
   localparam logic [9:0] O_BR1  = 10'b1111_1100_01;
   localparam logic [9:0] O_BR2  = 10'b1111_1100_10;
   localparam logic [9:0] O_FZ0  = 10'b0000_0010_00;
   localparam logic [9:0] O_FZ2  = 10'b0000_0010_10;
   localparam logic [9:0] O_ABT2 = 10'b1111_0011_10;
   localparam logic [9:0] O_RST  = 10'b0000_1110_00;

   typedef struct {
      logic       rst;
      logic [4:0] rs;
      logic [4:0] rt;
      logic       urt;
      logic [4:0] rd;
      logic       mrd;
      logic       br;
      logic       mreq;
      logic       mrdy;
      logic       ca;
      logic [9:0] ea;
      logic       cb;
      logic [9:0] eb;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] id_rs, id_rt, ex_rd;
   logic       id_uses_rt, ex_mem_read, ex_branch_taken, mem_req, mem_ready;

   logic       a_pc, a_ifw, a_idw, a_exw, a_iff, a_idf, a_bub, a_err;
   logic [1:0] a_st;
   logic       b_pc, b_ifw, b_idw, b_exw, b_iff, b_idf, b_bub, b_err;
   logic [1:0] b_st;
   logic [9:0] out_a, out_b;
`ifdef HAZARD_PERF_CNT_EN
   logic [15:0] a_pl, a_pm, a_pf, b_pl, b_pm, b_pf;
`endif

   int checks = 0;
   int errors = 0;
   int owed[2];
   int frozen[2];
   int burst = 0;

   always #5 clk = ~clk;

   assign out_a = {a_pc, a_ifw, a_idw, a_exw, a_iff, a_idf, a_bub, a_err, a_st};
   assign out_b = {b_pc, b_ifw, b_idw, b_exw, b_iff, b_idf, b_bub, b_err, b_st};

   hazard_stall_controller #(.REG_W(5), .NULL_REG(31), .LOAD_BUBBLES(LB_A), .MEM_TIMEOUT(T_A)) dut_a (
      .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
      .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
      .mem_req(mem_req), .mem_ready(mem_ready),
      .pc_write(a_pc), .ifid_write(a_ifw), .idex_write(a_idw), .exmem_write(a_exw),
      .ifid_flush(a_iff), .idex_flush(a_idf), .memwb_bubble(a_bub), .mem_err(a_err),
      .state(a_st)
`ifdef HAZARD_PERF_CNT_EN
      , .perf_load_stalls(a_pl), .perf_mem_waits(a_pm), .perf_flushes(a_pf)
`endif
   );

   hazard_stall_controller #(.REG_W(5), .NULL_REG(31), .LOAD_BUBBLES(LB_B), .MEM_TIMEOUT(T_B)) dut_b (
      .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
      .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
      .mem_req(mem_req), .mem_ready(mem_ready),
      .pc_write(b_pc), .ifid_write(b_ifw), .idex_write(b_idw), .exmem_write(b_exw),
      .ifid_flush(b_iff), .idex_flush(b_idf), .memwb_bubble(b_bub), .mem_err(b_err),
      .state(b_st)
`ifdef HAZARD_PERF_CNT_EN
      , .perf_load_stalls(b_pl), .perf_mem_waits(b_pm), .perf_flushes(b_pf)
`endif
   );

   function automatic vec_t mk(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                               input logic urt, input logic [4:0] rd, input logic mrd,
                               input logic br, input logic mreq, input logic mrdy,
                               input logic ca, input logic [9:0] ea,
                               input logic cb, input logic [9:0] eb);
      vec_t v;
      v.rst = r; v.rs = rs; v.rt = rt; v.urt = urt; v.rd = rd; v.mrd = mrd;
      v.br = br; v.mreq = mreq; v.mrdy = mrdy;
      v.ca = ca; v.ea = ea; v.cb = cb; v.eb = eb;
      return v;
   endfunction

   task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%b expected=%b at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model:
   //   - owed:   load-stall cycles still owed
   //   - frozen: consecutive memory-freeze cycles so far
   task automatic model_step(input int k, input vec_t v, output logic [9:0] e);
      int   lb, tmo, st;
      logic ms, lu;
      logic pc, fw, dw, xw, ff, df, bb, er;
      lb  = (k == 0) ? LB_A : LB_B;
      tmo = (k == 0) ? T_A : T_B;
      pc = 1'b1; fw = 1'b1; dw = 1'b1; xw = 1'b1;
      ff = 1'b0; df = 1'b0; bb = 1'b0; er = 1'b0;
      if (v.rst) begin
         owed[k]   = 0;
         frozen[k] = 0;
         e = O_RST;
      end else begin
         st = (frozen[k] > 0) ? 2 : ((owed[k] > 0) ? 1 : 0);
         ms = v.mreq && !v.mrdy;
         lu = v.mrd && (v.rd != 5'd31) && ((v.rd == v.rs) || (v.urt && (v.rd == v.rt)));
         if (ms && (frozen[k] < tmo - 1)) begin
            pc = 1'b0; fw = 1'b0; dw = 1'b0; xw = 1'b0; bb = 1'b1;
            frozen[k]++;
         end else if (ms) begin
            er = 1'b1; bb = 1'b1;
            frozen[k] = 0;
         end else begin
            frozen[k] = 0;
            if (v.br) begin
               ff = 1'b1; df = 1'b1;
               owed[k] = 0;
            end else if (owed[k] > 0) begin
               pc = 1'b0; fw = 1'b0; df = 1'b1;
               owed[k]--;
            end else if (lu) begin
               pc = 1'b0; fw = 1'b0; df = 1'b1;
               owed[k] = lb - 1;
            end
         end
         e = {pc, fw, dw, xw, ff, df, bb, er, 2'(st)};
      end
   endtask

   task automatic do_cycle(input vec_t v, input string tag);
      logic [9:0] ma, mb;
      @(negedge clk);
      rst = v.rst; id_rs = v.rs; id_rt = v.rt; id_uses_rt = v.urt; ex_rd = v.rd;
      ex_mem_read = v.mrd; ex_branch_taken = v.br; mem_req = v.mreq; mem_ready = v.mrdy;
      #2;
      model_step(0, v, ma);
      model_step(1, v, mb);
      check({tag, "/model_a"}, out_a, ma);
      check({tag, "/model_b"}, out_b, mb);
      if (v.ca) check({tag, "/exp_a"}, out_a, v.ea);
      if (v.cb) check({tag, "/exp_b"}, out_b, v.eb);
   endtask

   function automatic logic [4:0] pick();
      case ($urandom_range(0, 3))
         0:       return 5'd3;
         1:       return 5'd7;
         2:       return 5'd31;
         default: return 5'($urandom_range(0, 31));
      endcase
   endfunction

   vec_t tbl[13];
   vec_t idle, rstv, lu7, lu7n, memw, memr;

   initial begin
      rst = 1'b1; id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0; ex_rd = 5'd0;
      ex_mem_read = 1'b0; ex_branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
      owed[0] = 0; owed[1] = 0; frozen[0] = 0; frozen[1] = 0;

      tbl[0]  = mk(1'b1, 5'd0, 5'd0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, O_RST, 1'b1, O_RST);
      tbl[1]  = mk(1'b0, 5'd0, 5'd0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, O_RUN, 1'b1, O_RUN);
      tbl[2]  = mk(1'b0, 5'd3, 5'd0, 1'b0, 5'd3,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, O_LU0, 1'b1, O_LU0);
      tbl[3]  = mk(1'b0, 5'd0, 5'd0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, O_RUN, 1'b1, O_LU1);
      tbl[4]  = mk(1'b0, 5'd31,5'd0, 1'b0, 5'd31, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, O_RUN, 1'b1, O_LU1);
      tbl[5]  = mk(1'b0, 5'd1, 5'd7, 1'b0, 5'd7,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, O_RUN, 1'b1, O_RUN);
      tbl[6]  = mk(1'b0, 5'd1, 5'd7, 1'b1, 5'd7,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, O_LU0, 1'b1, O_LU0);
      tbl[7]  = mk(1'b0, 5'd3, 5'd0, 1'b0, 5'd3,  1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 10'b1111_1100_00, 1'b1, O_BR1);
      tbl[8]  = mk(1'b0, 5'd0, 5'd0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b1, 1'b1, 1'b1, O_RUN, 1'b1, O_RUN);
      tbl[9]  = mk(1'b0, 5'd0, 5'd0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1, O_FZ0, 1'b1, O_FZ0);
      tbl[10] = mk(1'b0, 5'd0, 5'd0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1, O_FZ2, 1'b1, O_FZ2);
      tbl[11] = mk(1'b0, 5'd0, 5'd0, 1'b0, 5'd0,  1'b0, 1'b1, 1'b1, 1'b1, 1'b1, O_BR2, 1'b1, O_BR2);
      tbl[12] = mk(1'b0, 5'd0, 5'd0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, O_RUN, 1'b1, O_RUN);
      for (int i = 0; i < 13; i++) do_cycle(tbl[i], $sformatf("tbl%0d", i));

      idle = mk(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_RUN, 1'b0, O_RUN);
      rstv = idle; rstv.rst = 1'b1;
      lu7  = mk(1'b0, 5'd0, 5'd7, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, O_RUN, 1'b0, O_RUN);
      lu7n = lu7; lu7n.urt = 1'b0;
      memw = idle; memw.mreq = 1'b1;
      memr = memw; memr.mrdy = 1'b1;

      // Three-bubble load-use on dut_b via rt, then the same without rt use
      do_cycle(rstv, "luB_rst");
      lu7.cb = 1'b1; lu7.eb = O_LU0; do_cycle(lu7, "luB_c1");
      idle.cb = 1'b1; idle.eb = O_LU1; do_cycle(idle, "luB_c2");
      do_cycle(idle, "luB_c3");
      idle.eb = O_RUN; do_cycle(idle, "luB_c4");
      lu7n.ca = 1'b1; lu7n.cb = 1'b1; do_cycle(lu7n, "luB_nort");

      // Five-cycle memory wait on dut_a
      do_cycle(rstv, "memA_rst");
      memw.ca = 1'b1; memw.ea = O_FZ0; do_cycle(memw, "memA_c1");
      memw.ea = O_FZ2;
      for (int i = 2; i <= 5; i++) do_cycle(memw, $sformatf("memA_c%0d", i));
      memr.ca = 1'b1; memr.ea = O_RUN2; do_cycle(memr, "memA_rdy");
      idle.ca = 1'b1; idle.cb = 1'b0; do_cycle(idle, "memA_after");

      // Timeout on dut_b: three freeze cycles, one abort, then normal
      do_cycle(rstv, "tmoB_rst");
      memw.ca = 1'b0; memw.cb = 1'b1; memw.eb = O_FZ0; do_cycle(memw, "tmoB_c1");
      memw.eb = O_FZ2; do_cycle(memw, "tmoB_c2");
      do_cycle(memw, "tmoB_c3");
      memw.eb = O_ABT2; do_cycle(memw, "tmoB_abort");
      idle.ca = 1'b0; idle.cb = 1'b1; idle.eb = O_RUN; do_cycle(idle, "tmoB_after");

      // Branch during LOAD_STALL cancels remaining bubbles
      do_cycle(rstv, "brB_rst");
      do_cycle(lu7, "brB_lu");
      idle.eb = O_LU1; do_cycle(idle, "brB_ls");
      idle.br = 1'b1; idle.eb = O_BR1; do_cycle(idle, "brB_br");
      idle.br = 1'b0; idle.eb = O_RUN; do_cycle(idle, "brB_after");

      // Reset mid-stall, then a full fresh stall
      do_cycle(rstv, "rstB_rst");
      do_cycle(lu7, "rstB_lu");
      rstv.cb = 1'b1; rstv.eb = O_RST; do_cycle(rstv, "rstB_mid");
`ifdef HAZARD_PERF_CNT_EN
      check("perf_zero_a", {a_pl[3:0], a_pm[3:0], 2'b00}, 10'd0);
      check("perf_zero_b", {b_pl[3:0], b_pm[3:0], b_pf[1:0]}, 10'd0);
`endif
      do_cycle(lu7, "rstB_lu2");
      idle.eb = O_LU1; do_cycle(idle, "rstB_c2");
      do_cycle(idle, "rstB_c3");
      idle.eb = O_RUN; do_cycle(idle, "rstB_c4");

      // Randomized traffic against the reference model
      for (int n = 0; n < 3000; n++) begin
         vec_t v;
         if (burst == 0 && $urandom_range(0, 9) == 0) burst = $urandom_range(1, 80);
         v = mk(($urandom_range(0, 299) == 0), pick(), pick(), 1'($urandom_range(0, 1)),
                pick(), 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
                (burst > 0), ($urandom_range(0, 15) == 0), 1'b0, O_RUN, 1'b0, O_RUN);
         if (burst > 0) burst--;
         do_cycle(v, "rand");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
